// File: rtl/hog_regs_pkg.sv
// Shared register map, bit positions and AXI response codes for the HOG GP control register bank.
package hog_regs_pkg;

    localparam int CTRL_IDX     = 0;
    localparam int STATUS_IDX   = 1;
    localparam int CFG_BASE_IDX = 2;

    localparam int START_BIT     = 0;
    localparam int IRQ_EN_BIT    = 1;
    localparam int BUSY_BIT      = 0;
    localparam int DONE_BIT      = 1;
    localparam int START_ERR_BIT = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    function automatic axi_resp_e resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/hog_axil_wr_ctrl.sv
// AXI4-Lite write channel front end: latches AW and W independently, emits a one-cycle
// commit strobe once both are held, and owns the B channel until the master accepts it.
module hog_axil_wr_ctrl
    import hog_regs_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  ADDR_WIDTH = 5,
    parameter int  NUM_REGS   = 8,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int IDX_LSB    = $clog2(STRB_W),
    localparam int IDX_W      = ADDR_WIDTH - IDX_LSB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr_i,
    input  logic                  s_axi_awvalid_i,
    output logic                  s_axi_awready_o,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata_i,
    input  logic [STRB_W-1:0]     s_axi_wstrb_i,
    input  logic                  s_axi_wvalid_i,
    output logic                  s_axi_wready_o,
    output logic [1:0]            s_axi_bresp_o,
    output logic                  s_axi_bvalid_o,
    input  logic                  s_axi_bready_i,
    output logic                  commit_o,
    output logic                  commit_ok_o,
    output logic [IDX_W-1:0]      commit_idx_o,
    output logic [DATA_WIDTH-1:0] commit_data_o,
    output logic [STRB_W-1:0]     commit_strb_o
);

    logic                  aw_held_q;
    logic                  w_held_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  bvalid_q;
    axi_resp_e             bresp_q;
    logic                  in_range;
    logic                  unused_awaddr_lsbs;

    assign unused_awaddr_lsbs = ^s_axi_awaddr_i[IDX_LSB-1:0];

    // Readies drop during reset so the master sees no acceptance while the bank is cleared.
    assign s_axi_awready_o = !rst && !aw_held_q && !bvalid_q;
    assign s_axi_wready_o  = !rst && !w_held_q && !bvalid_q;

    assign in_range      = int'(idx_q) < NUM_REGS;
    assign commit_o      = aw_held_q && w_held_q;
    assign commit_ok_o   = in_range;
    assign commit_idx_o  = idx_q;
    assign commit_data_o = wdata_q;
    assign commit_strb_o = wstrb_q;

    assign s_axi_bvalid_o = bvalid_q;
    assign s_axi_bresp_o  = bresp_q;

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every register samples the pre-edge values of its peers.
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (s_axi_awvalid_i && s_axi_awready_o) begin
                aw_held_q <= 1'b1;
                idx_q     <= s_axi_awaddr_i[ADDR_WIDTH-1:IDX_LSB];
            end
            if (s_axi_wvalid_i && s_axi_wready_o) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi_wdata_i;
                wstrb_q  <= s_axi_wstrb_i;
            end
            if (commit_o) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= resp_for(in_range);
            end else if (bvalid_q && s_axi_bready_i) begin
                bvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hog_axil_regbank.sv
// AXI4-Lite register bank for the HOG core: CTRL/STATUS/config storage, read channel,
// start pulse generation and the done interrupt.
module hog_axil_regbank
    import hog_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDR_WIDTH-1:0]                s_axi_awaddr,
    input  logic                                 s_axi_awvalid,
    output logic                                 s_axi_awready,
    input  logic [DATA_WIDTH-1:0]                s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]              s_axi_wstrb,
    input  logic                                 s_axi_wvalid,
    output logic                                 s_axi_wready,
    output logic [1:0]                           s_axi_bresp,
    output logic                                 s_axi_bvalid,
    input  logic                                 s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]                s_axi_araddr,
    input  logic                                 s_axi_arvalid,
    output logic                                 s_axi_arready,
    output logic [DATA_WIDTH-1:0]                s_axi_rdata,
    output logic [1:0]                           s_axi_rresp,
    output logic                                 s_axi_rvalid,
    input  logic                                 s_axi_rready,
    output logic                                 start_o,
    input  logic                                 busy_i,
    input  logic                                 done_i,
    output logic [(NUM_REGS-2)*DATA_WIDTH-1:0]   cfg_o,
    output logic                                 irq_o
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(STRB_W);
    localparam int IDX_W   = ADDR_WIDTH - IDX_LSB;
    localparam int NUM_CFG = NUM_REGS - CFG_BASE_IDX;

    logic                  wr_commit;
    logic                  wr_ok;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;

    logic                  irq_en_q;
    logic                  done_q, done_d;
    logic                  start_err_q, start_err_d;
    logic                  start_q;
    logic                  irq_q;
    logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];

    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    axi_resp_e             rresp_q;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_araddr_lsbs;

    logic wr_ctrl, wr_status, start_req, done_clr, err_clr;

    hog_axil_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_ctrl (
        .clk             (clk),
        .rst             (rst),
        .s_axi_awaddr_i  (s_axi_awaddr),
        .s_axi_awvalid_i (s_axi_awvalid),
        .s_axi_awready_o (s_axi_awready),
        .s_axi_wdata_i   (s_axi_wdata),
        .s_axi_wstrb_i   (s_axi_wstrb),
        .s_axi_wvalid_i  (s_axi_wvalid),
        .s_axi_wready_o  (s_axi_wready),
        .s_axi_bresp_o   (s_axi_bresp),
        .s_axi_bvalid_o  (s_axi_bvalid),
        .s_axi_bready_i  (s_axi_bready),
        .commit_o        (wr_commit),
        .commit_ok_o     (wr_ok),
        .commit_idx_o    (wr_idx),
        .commit_data_o   (wr_data),
        .commit_strb_o   (wr_strb)
    );

    function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0] old_val,
                                                         input logic [DATA_WIDTH-1:0] new_val,
                                                         input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // CTRL and STATUS bits all live in byte lane 0, so lane 0 gates every control side effect.
    assign wr_ctrl   = wr_commit && wr_ok && wr_idx == IDX_W'(CTRL_IDX) && wr_strb[0];
    assign wr_status = wr_commit && wr_ok && wr_idx == IDX_W'(STATUS_IDX) && wr_strb[0];
    assign start_req = wr_ctrl && wr_data[START_BIT];
    assign done_clr  = wr_status && wr_data[DONE_BIT];
    assign err_clr   = wr_status && wr_data[START_ERR_BIT];

    // Set beats a same-cycle W1C clear so no completion event is lost.
    assign done_d      = done_i || (done_q && !done_clr);
    assign start_err_d = (start_req && busy_i) || (start_err_q && !err_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            start_q     <= 1'b0;
            irq_q       <= 1'b0;
            // NOTE: the config file is small and software expects zeros, so every entry is reset.
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
        end else begin
            start_q     <= start_req && !busy_i;
            done_q      <= done_d;
            start_err_q <= start_err_d;
            irq_q       <= irq_en_q && done_q;
            if (wr_ctrl) irq_en_q <= wr_data[IRQ_EN_BIT];
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_commit && wr_idx == IDX_W'(CFG_BASE_IDX + i))
                    cfg_q[i] <= merge_strb(cfg_q[i], wr_data, wr_strb);
            end
        end
    end

    assign unused_araddr_lsbs = ^s_axi_araddr[IDX_LSB-1:0];
    assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:IDX_LSB];

    always_comb begin
        // NOTE: defaults first so no branch leaves rd_val/rd_ok unassigned and a latch is inferred.
        rd_val = '0;
        rd_ok  = int'(rd_idx) < NUM_REGS;
        if (rd_idx == IDX_W'(CTRL_IDX)) begin
            rd_val[IRQ_EN_BIT] = irq_en_q;
        end else if (rd_idx == IDX_W'(STATUS_IDX)) begin
            rd_val[BUSY_BIT]      = busy_i;
            rd_val[DONE_BIT]      = done_q;
            rd_val[START_ERR_BIT] = start_err_q;
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_idx == IDX_W'(CFG_BASE_IDX + i)) rd_val = cfg_q[i];
        end
    end

    assign s_axi_arready = !rst && !rvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? rd_val : '0;
            rresp_q  <= resp_for(rd_ok);
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    always_comb begin
        cfg_o = '0;
        for (int i = 0; i < NUM_CFG; i++) cfg_o[i*DATA_WIDTH +: DATA_WIDTH] = cfg_q[i];
    end

    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign start_o      = start_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_hog_axil_regbank.sv
// Self-checking bench: directed scenarios plus randomized register traffic against a behavioural model.
module tb_hog_axil_regbank;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 6;
    localparam int NCFG = NR - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    s_axi_awaddr;
    logic             s_axi_awvalid, s_axi_awready;
    logic [DW-1:0]    s_axi_wdata;
    logic [DW/8-1:0]  s_axi_wstrb;
    logic             s_axi_wvalid, s_axi_wready;
    logic [1:0]       s_axi_bresp;
    logic             s_axi_bvalid, s_axi_bready;
    logic [AW-1:0]    s_axi_araddr;
    logic             s_axi_arvalid, s_axi_arready;
    logic [DW-1:0]    s_axi_rdata;
    logic [1:0]       s_axi_rresp;
    logic             s_axi_rvalid, s_axi_rready;
    logic             start_o, busy_i, done_i, irq_o;
    logic [NCFG*DW-1:0] cfg_o;

    always #5 clk = ~clk;

    hog_axil_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .start_o(start_o),
        .busy_i(busy_i), .done_i(done_i), .cfg_o(cfg_o), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents by word index plus the status/control flags.
    logic [31:0] m_reg [NR];
    logic        m_irq_en, m_done, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        m_irq_en = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        logic [31:0] v;
        v = '0;
        if (idx == 0)       v[1] = m_irq_en;
        else if (idx == 1)  v = {29'd0, m_err, m_done, busy_i};
        else if (idx < NR)  v = m_reg[idx];
        return v;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                                        input logic busy, input logic done_in,
                                        output logic exp_start, output logic [1:0] exp_resp);
        exp_start = 1'b0;
        exp_resp  = (idx < NR) ? OKAY : SLVERR;
        if (idx == 0 && s[0]) begin
            m_irq_en = d[1];
            if (d[0]) begin
                if (busy) m_err = 1'b1;
                else      exp_start = 1'b1;
            end
        end else if (idx == 1 && s[0]) begin
            if (d[1]) m_done = 1'b0;
            if (d[2]) m_err = 1'b0;
        end else if (idx >= 2 && idx < NR) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
        end
        if (done_in) m_done = 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " irq"}, 32'(irq_o), 32'(m_irq_en & m_done));
        for (int i = 0; i < NCFG; i++) check({tag, " cfg"}, cfg_o[i*DW +: DW], m_reg[i+2]);
    endtask

    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_hold, input string tag);
        logic       exp_start;
        logic [1:0] exp_resp;
        logic [1:0] addr_lsb;
        bit         aw_done = 0, w_done = 0, aw_hs, w_hs;
        int         cyc = 0, starts = 0;
        model_write(idx, data, strb, busy_i, done_i, exp_start, exp_resp);
        addr_lsb     = 2'($urandom);
        s_axi_bready = (b_hold == 0);
        while (!(aw_done && w_done)) begin
            s_axi_awaddr  = {3'(idx), addr_lsb};
            s_axi_awvalid = !aw_done && cyc >= aw_dly;
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_wvalid  = !w_done && cyc >= w_dly;
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick();
            if (start_o) starts++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
            if (cyc > 40) begin
                s_axi_awvalid = 1'b0;
                s_axi_wvalid  = 1'b0;
                check({tag, " handshake timeout"}, 0, 1);
                return;
            end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        cyc = 0;
        while (!s_axi_bvalid) begin
            tick();
            if (start_o) starts++;
            cyc++;
            if (cyc > 10) begin
                check({tag, " bvalid timeout"}, 0, 1);
                return;
            end
        end
        check({tag, " bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
        check({tag, " start with b"}, 32'(start_o), 32'(exp_start));
        for (int c = 0; c < b_hold; c++) begin
            tick();
            if (start_o) starts++;
            check({tag, " bvalid held"}, 32'(s_axi_bvalid), 1);
            check({tag, " bresp held"}, 32'(s_axi_bresp), 32'(exp_resp));
            check({tag, " awready blocked"}, 32'(s_axi_awready), 0);
            check({tag, " wready blocked"}, 32'(s_axi_wready), 0);
        end
        s_axi_bready = 1'b1;
        tick();
        if (start_o) starts++;
        check({tag, " bvalid drop"}, 32'(s_axi_bvalid), 0);
        check({tag, " start count"}, 32'(starts), 32'(exp_start));
        check_outputs(tag);
    endtask

    task automatic axi_read(input int idx, input int r_hold, input string tag, output logic [31:0] got);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit          hs;
        int          cyc = 0;
        got          = 'x;
        exp_data     = model_read(idx);
        exp_resp     = (idx < NR) ? OKAY : SLVERR;
        s_axi_araddr = {3'(idx), 2'($urandom)};
        s_axi_arvalid = 1'b1;
        s_axi_rready  = (r_hold == 0);
        do begin
            hs = s_axi_arready;
            tick();
            cyc++;
            if (cyc > 20) begin
                s_axi_arvalid = 1'b0;
                check({tag, " arready timeout"}, 0, 1);
                return;
            end
        end while (!hs);
        s_axi_arvalid = 1'b0;
        check({tag, " rvalid"}, 32'(s_axi_rvalid), 1);
        check({tag, " rdata"}, s_axi_rdata, exp_data);
        check({tag, " rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
        got = s_axi_rdata;
        for (int c = 0; c < r_hold; c++) begin
            tick();
            check({tag, " rdata held"}, s_axi_rdata, exp_data);
            check({tag, " arready blocked"}, 32'(s_axi_arready), 0);
        end
        s_axi_rready = 1'b1;
        tick();
        check({tag, " rvalid drop"}, 32'(s_axi_rvalid), 0);
    endtask

    task automatic pulse_done();
        logic old_irq;
        old_irq = m_irq_en & m_done;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        m_done = 1'b1;
        check("irq latency", 32'(irq_o), 32'(old_irq));
        tick();
        check("irq after done", 32'(irq_o), 32'(m_irq_en));
    endtask

    initial begin
        logic [31:0] got;
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1; busy_i = 1'b0; done_i = 1'b0;
        model_reset();
        repeat (3) tick();

        check("reset awready", 32'(s_axi_awready), 0);
        check("reset wready", 32'(s_axi_wready), 0);
        check("reset arready", 32'(s_axi_arready), 0);
        check("reset bvalid", 32'(s_axi_bvalid), 0);
        check("reset rvalid", 32'(s_axi_rvalid), 0);
        check("reset rdata", s_axi_rdata, 0);
        check("reset start", 32'(start_o), 0);
        check_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) axi_read(i, 0, "reset read", got);
        busy_i = 1'b1;
        axi_read(1, 0, "status busy", got);
        check("status busy value", got, 32'h1);
        busy_i = 1'b0;

        axi_write(3, 32'hDEADBEEF, 4'hF, 1, 0, 0, "w before aw");
        axi_write(3, 32'h0000_1200, 4'b0010, 0, 0, 0, "lane1 strobe");
        axi_read(3, 0, "reg3", got);
        check("reg3 merged", got, 32'hDEAD12EF);
        axi_write(2, 32'h1234_5678, 4'h0, 0, 2, 0, "zero strobe");

        axi_write(0, 32'h3, 4'h1, 0, 0, 0, "ctrl start");
        axi_read(0, 0, "ctrl readback", got);
        check("ctrl value", got, 32'h2);
        pulse_done();
        axi_read(1, 0, "status done", got);
        check("status done value", got, 32'h2);
        axi_write(1, 32'h2, 4'h1, 0, 0, 0, "done w1c");
        check("irq cleared", 32'(irq_o), 0);

        busy_i = 1'b1;
        axi_write(0, 32'h1, 4'h1, 0, 0, 0, "start while busy");
        axi_read(1, 0, "status err", got);
        check("status err value", got, 32'h5);
        busy_i = 1'b0;
        done_i = 1'b1;
        axi_write(1, 32'h6, 4'h1, 0, 0, 0, "w1c vs set");
        done_i = 1'b0;
        axi_read(1, 0, "status set wins", got);
        check("status set wins value", got, 32'h2);

        axi_write(7, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "oor write 7");
        axi_write(6, 32'hA5A5_A5A5, 4'hF, 2, 1, 0, "oor write 6");
        axi_read(7, 0, "oor read 7", got);
        check("oor rdata", got, 32'h0);

        axi_write(5, 32'hCAFE_F00D, 4'hF, 0, 0, 5, "bready hold");
        fork
            axi_write(4, 32'h0BAD_CAFE, 4'hF, 0, 0, 0, "concurrent write");
            axi_read(3, 0, "concurrent read", got);
        join

        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                axi_write(int'($urandom_range(0, 7)), $urandom, 4'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), "rand write");
            end else if (op < 8) begin
                axi_read(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), "rand read", got);
            end else if (op == 8) begin
                pulse_done();
            end else begin
                busy_i = 1'($urandom_range(0, 1));
                tick();
            end
        end

        s_axi_araddr  = 5'h0C;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        check("pre-reset rvalid", 32'(s_axi_rvalid), 1);
        rst = 1'b1;
        tick();
        check("mid-read reset rvalid", 32'(s_axi_rvalid), 0);
        check("mid-read reset bvalid", 32'(s_axi_bvalid), 0);
        rst = 1'b0;
        s_axi_rready = 1'b1;
        busy_i = 1'b0;
        model_reset();
        tick();
        check_outputs("after reset");
        for (int i = 0; i < NR; i++) axi_read(i, 0, "after reset read", got);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
